// File: rtl/pio_irq_debounce.sv
// pio_irq_debounce
//   Avalon-MM PIO block for the lightweight HPS-to-FPGA bridge. It has IN_W
//   debounced input channels, each with edge capture and an interrupt mask,
//   and OUT_W output bits with atomic set and clear. One registered level
//   IRQ is driven to the HPS.
//
// Ports
//   clk           : single clock
//   reset         : asynchronous, active-high reset
//   avs_address   : word address (8 registers)
//   avs_read      : read strobe; avs_readdata is valid one cycle later
//   avs_write     : write strobe
//   avs_writedata : write data
//   avs_readdata  : read data, held until the next read
//   irq           : level interrupt, |(EDGE_CAP & IRQ_MASK), registered
//   pio_in        : raw asynchronous inputs (buttons, switches)
//   pio_out       : output register (LEDs)
//
// Register map (word addresses)
//   0 DATA (RO)   1 IRQ_MASK (RW)   2 EDGE_CAP (R/W1C)   3 OUT (RW)
//   4 OUT_SET (WO) 5 OUT_CLR (WO)   6 DEB_CFG (RW)       7 ID (RO)
module pio_irq_debounce #(
  parameter int IN_W        = 4,
  parameter int OUT_W       = 8,
  parameter int DEB_W       = 20,
  parameter int DEB_DEFAULT = 500000,
  parameter int EDGE_MODE   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [IN_W-1:0]  pio_in,
  output logic [OUT_W-1:0] pio_out
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);
  // ID layout: 0x51 tag, zero padding, 2-bit edge mode, OUT_W, IN_W.
  localparam logic [31:0] ID_VAL = {8'h51, 6'b0, 2'(EDGE_MODE), 8'(OUT_W), 8'(IN_W)};

  // Upper write-data bits are not used by every register width.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // ---------------- input synchroniser ----------------
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] sync_w;
  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // ---------------- priming ----------------
  // The synchroniser holds reset zeros for SYNC_STAGES cycles; once it has
  // filled, stable is loaded straight from it so no edge is seen at startup.
  logic [PRIME_W-1:0] prime_cnt_q;
  logic               primed_q;
  logic               prime_load;
  assign prime_load = !primed_q && (prime_cnt_q == PRIME_W'(SYNC_STAGES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else if (prime_load) begin
      primed_q    <= 1'b1;
    end else if (!primed_q) begin
      prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
    end
  end

  // ---------------- bus decode ----------------
  logic wr_mask, wr_cap, wr_out, wr_set, wr_clr, wr_deb;
  assign wr_mask = avs_write && (avs_address == 3'd1);
  assign wr_cap  = avs_write && (avs_address == 3'd2);
  assign wr_out  = avs_write && (avs_address == 3'd3);
  assign wr_set  = avs_write && (avs_address == 3'd4);
  assign wr_clr  = avs_write && (avs_address == 3'd5);
  assign wr_deb  = avs_write && (avs_address == 3'd6);

  // ---------------- debounce ----------------
  logic [DEB_W-1:0] deb_cfg_q;
  logic [DEB_W-1:0] cnt_q [IN_W];
  logic [DEB_W-1:0] cnt_d [IN_W];
  logic [IN_W-1:0]  stable_q, stable_d, prev_q;
  logic             cfg_zero;
  assign cfg_zero = (deb_cfg_q == '0);

  for (genvar gi = 0; gi < IN_W; gi++) begin : g_deb
    logic differs;
    logic match;
    assign differs = sync_w[gi] ^ stable_q[gi];
    // Accept the new level on the DEB_CFG-th consecutive differing cycle.
    assign match   = (cnt_q[gi] == deb_cfg_q - DEB_W'(1));

    assign stable_d[gi] = prime_load                ? sync_w[gi]   :
                          !primed_q                 ? stable_q[gi] :
                          cfg_zero                  ? sync_w[gi]   :
                          (differs && match)        ? sync_w[gi]   :
                                                      stable_q[gi];

    // A DEB_CFG write restarts every count so the new threshold applies cleanly.
    assign cnt_d[gi] = (!primed_q || cfg_zero || !differs || match || wr_deb)
                       ? '0 : cnt_q[gi] + DEB_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int k = 0; k < IN_W; k++) cnt_q[k] <= '0;
    end else begin
      stable_q <= stable_d;
      // Priming loads prev too, so the initial load is not seen as an edge.
      prev_q   <= prime_load ? sync_w : stable_q;
      for (int k = 0; k < IN_W; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // ---------------- edge detect ----------------
  logic [IN_W-1:0] rise_w, fall_w, event_w;
  assign rise_w = stable_q & ~prev_q;
  assign fall_w = ~stable_q & prev_q;

  always_comb begin
    event_w = rise_w | fall_w;
    case (EDGE_MODE)
      0:       event_w = rise_w;
      1:       event_w = fall_w;
      default: event_w = rise_w | fall_w;
    endcase
  end

  // ---------------- registers ----------------
  logic [IN_W-1:0]  irq_mask_q, edge_cap_q, edge_cap_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [31:0]      rdata_q, rd_mux;
  logic             irq_q;

  // New events win over a simultaneous W1C on the same bit.
  assign edge_cap_d = (edge_cap_q & ~(wr_cap ? avs_writedata[IN_W-1:0] : '0)) | event_w;

  always_comb begin
    out_d = out_q;
    if (wr_out) out_d = avs_writedata[OUT_W-1:0];
    if (wr_set) out_d = out_q | avs_writedata[OUT_W-1:0];
    if (wr_clr) out_d = out_q & ~avs_writedata[OUT_W-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux[IN_W-1:0]  = stable_q;
      3'd1: rd_mux[IN_W-1:0]  = irq_mask_q;
      3'd2: rd_mux[IN_W-1:0]  = edge_cap_q;
      3'd3: rd_mux[OUT_W-1:0] = out_q;
      3'd6: rd_mux[DEB_W-1:0] = deb_cfg_q;
      3'd7: rd_mux            = ID_VAL;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      out_q      <= '0;
      deb_cfg_q  <= DEB_W'(DEB_DEFAULT);
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_mask) irq_mask_q <= avs_writedata[IN_W-1:0];
      if (wr_deb)  deb_cfg_q  <= avs_writedata[DEB_W-1:0];
      edge_cap_q <= edge_cap_d;
      out_q      <= out_d;
      irq_q      <= |(edge_cap_q & irq_mask_q);
      // Mux uses current register values, so a same-cycle write is not seen.
      if (avs_read) rdata_q <= rd_mux;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign pio_out      = out_q;

endmodule
